// File: rtl/mc_pkg.sv
// Shared constants for the multicycle CPU control path: state codes and the
// default counter width. The datapath decodes `state` with the same codes.
package mc_pkg;

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EXE = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  localparam int CNT_W_DFLT = 32;

endpackage

// File: rtl/multicycle_ctrl_perf_counter.sv
// Free-running wrap-around event counter used for cycle and retire tracing.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next value: +1 on an event, wrapping modulo 2^CNT_W.
  always_comb begin
    cnt_d = cnt_q;
    if (inc) cnt_d = cnt_q + CNT_W'(1);
  end

  // Reset dominates, including a coincident wrap.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM stepping the shared datapath through IF/ID/EXE/MEM/WB, one
// instruction at a time, with wait states from the instruction/data SRAMs.
// Strobes are a decode of the current state; pc_we additionally looks at the
// decoded instruction in EXE and at data_ready in MEM so a branch or store
// retires in the cycle it leaves that state.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = CNT_W_DFLT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             gr_we,
  input  logic             inst_ready,
  input  logic             data_ready,
  output logic             inst_req,
  output logic             ir_we,
  output logic             data_req,
  output logic             data_sram_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  logic [2:0] state_q;
  logic       is_mem;

  // A load+store encoding is treated as a load everywhere below.
  assign is_mem = is_load | is_store;

  // State sequencing; illegal codes fall back to IF.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IF;
    end else begin
      case (state_q)
        S_IF:    if (inst_ready) state_q <= S_ID;
        S_ID:    state_q <= S_EXE;
        S_EXE: begin
          if (is_mem)     state_q <= S_MEM;
          else if (gr_we) state_q <= S_WB;
          else            state_q <= S_IF;
        end
        S_MEM:   if (data_ready) state_q <= is_load ? S_WB : S_IF;
        S_WB:    state_q <= S_IF;
        default: state_q <= S_IF;
      endcase
    end
  end

  // Strobe decode; held low while reset is asserted so nothing partial leaks.
  always_comb begin
    inst_req     = 1'b0;
    ir_we        = 1'b0;
    data_req     = 1'b0;
    data_sram_we = 1'b0;
    rf_we        = 1'b0;
    pc_we        = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IF:  inst_req = 1'b1;
        S_ID:  ir_we    = 1'b1;
        S_EXE: pc_we    = ~is_mem & ~gr_we;
        S_MEM: begin
          data_req     = 1'b1;
          data_sram_we = is_store & ~is_load;
          pc_we        = data_ready & ~is_load;
        end
        S_WB: begin
          rf_we = 1'b1;
          pc_we = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

  perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (1'b1),
    .cnt   (cycle_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_instret_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (pc_we),
    .cnt   (instret_cnt)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl with 4-bit counters so wraps show up.
module tb_multicycle_ctrl;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       reset, is_load, is_store, gr_we, inst_ready, data_ready;
  logic       inst_req, ir_we, data_req, data_sram_we, rf_we, pc_we;
  logic [2:0] state;
  logic [3:0] cycle_cnt, instret_cnt;
  logic [5:0] sb_o;

  typedef struct packed {
    logic [2:0] st;
    logic [5:0] sb;
    logic [3:0] cyc;
    logic [3:0] ret;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_cyc, exp_ret;

  always #5 clk = ~clk;

  assign sb_o = {inst_req, ir_we, data_req, data_sram_we, rf_we, pc_we};

  multicycle_ctrl #(.CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .is_load      (is_load),
    .is_store     (is_store),
    .gr_we        (gr_we),
    .inst_ready   (inst_ready),
    .data_ready   (data_ready),
    .inst_req     (inst_req),
    .ir_we        (ir_we),
    .data_req     (data_req),
    .data_sram_we (data_sram_we),
    .rf_we        (rf_we),
    .pc_we        (pc_we),
    .state        (state),
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus: push the expected picture, drive, compare at negedge.
  task automatic cyc(input logic [2:0] st, input logic ir, input logic dr, input logic pcw);
    exp_t e, o;
    e.st  = st;
    e.sb  = {st == S_IF, st == S_ID, st == S_MEM,
             (st == S_MEM) && is_store && !is_load, st == S_WB, pcw};
    e.cyc = exp_cyc;
    e.ret = exp_ret;
    sbq.push_back(e);
    inst_ready = ir;
    data_ready = dr;
    @(negedge clk);
    o = sbq.pop_front();
    chk("state",   32'(state),       32'(o.st));
    chk("strobes", 32'(sb_o),        32'(o.sb));
    chk("cyc_cnt", 32'(cycle_cnt),   32'(o.cyc));
    chk("ret_cnt", 32'(instret_cnt), 32'(o.ret));
    exp_cyc++;
    if (pcw) exp_ret++;
    @(posedge clk); #1;
  endtask

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  // Full instruction with ifs fetch stalls and ms data stalls.
  task automatic run_instr(input logic ld, input logic st, input logic gw,
                           input int ifs, input int ms);
    is_load  = ld;
    is_store = st;
    gr_we    = gw;
    repeat (ifs) cyc(S_IF, 1'b0, rnd(), 1'b0);
    cyc(S_IF, 1'b1, rnd(), 1'b0);
    cyc(S_ID, rnd(), rnd(), 1'b0);
    if (ld | st) begin
      cyc(S_EXE, rnd(), rnd(), 1'b0);
      repeat (ms) cyc(S_MEM, rnd(), 1'b0, 1'b0);
      cyc(S_MEM, rnd(), 1'b1, !ld);
      if (ld) cyc(S_WB, rnd(), rnd(), 1'b1);
    end else if (gw) begin
      cyc(S_EXE, rnd(), rnd(), 1'b0);
      cyc(S_WB, rnd(), rnd(), 1'b1);
    end else begin
      cyc(S_EXE, rnd(), rnd(), 1'b1);
    end
  endtask

  // Assert reset for 1+n cycles; strobes must be low immediately, and state
  // and counters cleared from the following cycle on.
  task automatic do_reset(input int n);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_strobes", 32'(sb_o), 32'd0);
    @(posedge clk); #1;
    repeat (n) begin
      @(negedge clk);
      chk("rst_state",   32'(state),       32'(S_IF));
      chk("rst_strobes", 32'(sb_o),        32'd0);
      chk("rst_cyc_cnt", 32'(cycle_cnt),   32'd0);
      chk("rst_ret_cnt", 32'(instret_cnt), 32'd0);
      @(posedge clk); #1;
    end
    reset   = 1'b0;
    exp_cyc = '0;
    exp_ret = '0;
    sbq.delete();
  endtask

  initial begin
    reset      = 1'b1;
    is_load    = 1'b0;
    is_store   = 1'b0;
    gr_we      = 1'b0;
    inst_ready = 1'b1;
    data_ready = 1'b1;
    exp_cyc    = '0;
    exp_ret    = '0;

    do_reset(2);

    run_instr(1'b0, 1'b0, 1'b1, 0, 0);   // ALU op
    run_instr(1'b1, 1'b0, 1'b1, 0, 2);   // load, 2 data stalls
    run_instr(1'b0, 1'b1, 1'b0, 0, 0);   // store
    run_instr(1'b0, 1'b0, 1'b0, 0, 0);   // beq
    run_instr(1'b0, 1'b0, 1'b1, 3, 0);   // bl with fetch stalls
    run_instr(1'b1, 1'b1, 1'b1, 1, 1);   // load+store -> load
    run_instr(1'b0, 1'b1, 1'b0, 2, 3);   // store with both stall kinds

    // Reset in the middle of a stalled store.
    is_load  = 1'b0;
    is_store = 1'b1;
    gr_we    = 1'b0;
    cyc(S_IF,  1'b1, 1'b1, 1'b0);
    cyc(S_ID,  1'b1, 1'b1, 1'b0);
    cyc(S_EXE, 1'b1, 1'b1, 1'b0);
    cyc(S_MEM, 1'b1, 1'b0, 1'b0);
    do_reset(1);
    run_instr(1'b0, 1'b0, 1'b1, 0, 0);

    // 16 ALU ops from reset: retire counter wraps back to 0.
    do_reset(1);
    repeat (16) run_instr(1'b0, 1'b0, 1'b1, 0, 0);
    cyc(S_IF, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
